sign_div: RTL and testbench

Sequential signed fixed-point divider that computes C = A / B on WORD_MID-bit two's-complement operands with FRAC_BITS fractional bits. It is the inverse of the butterfly_sum signed multiplier, in the same Q format. It serves normalisation and scaling paths in the FFT pipeline where a quotient is needed. It uses restoring division, one quotient bit per clock, behind a start/busy/done handshake.

---
 rtl/sign_div.sv | 193 +++++++++++++++++++
 tb/tb_sign_div.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sign_div.sv
// sign_div: sequential signed fixed-point divider, C = A / B.
// Operands and result are WORD_MID-bit two's complement with FRAC_BITS
// fractional bits. Restoring division on magnitudes, one quotient bit per
// clock, then sign application with saturation. Truncates toward zero.
//
// Ports:
//   CLK      clock, all state updates on the rising edge
//   RST      synchronous active-high reset
//   start    request, sampled only in IDLE (A and B sampled with it)
//   A, B     dividend / divisor
//   busy     high while in DIVIDE or FINISH
//   done     one-cycle pulse when C and the flags are valid
//   C        quotient, held until the next completion
//   overflow result saturated; held with C
//   div_zero divisor was zero; held with C
module sign_div #(
  parameter int WORD_MID  = 16,
  parameter int FRAC_BITS = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [WORD_MID-1:0] A,
  input  logic [WORD_MID-1:0] B,
  output logic                busy,
  output logic                done,
  output logic [WORD_MID-1:0] C,
  output logic                overflow,
  output logic                div_zero
);

  localparam int N  = WORD_MID + FRAC_BITS;
  localparam int CW = $clog2(N);

  // Largest positive / negative magnitudes representable in WORD_MID bits
  localparam logic [N-1:0] POS_MAX = {{(N-WORD_MID+1){1'b0}}, {(WORD_MID-1){1'b1}}};
  localparam logic [N-1:0] NEG_MAX = {{(N-WORD_MID){1'b0}}, 1'b1, {(WORD_MID-1){1'b0}}};
  localparam logic [WORD_MID-1:0] SAT_POS = {1'b0, {(WORD_MID-1){1'b1}}};
  localparam logic [WORD_MID-1:0] SAT_NEG = {1'b1, {(WORD_MID-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]       cnt;
  logic [N-1:0]        dvd;
  logic [N-1:0]        quo;
  logic [WORD_MID:0]   rem;
  logic [WORD_MID-1:0] b_mag;
  logic                sign;
  logic                a_neg;
  logic                dz;

  // Operand magnitudes; the most negative value maps to 2^(WORD_MID-1)
  // because the result is read as unsigned.
  logic [WORD_MID-1:0] a_mag_in;
  logic [WORD_MID-1:0] b_mag_in;
  logic                b_is_zero;

  always_comb begin
    a_mag_in  = A[WORD_MID-1] ? ('0 - A) : A;
    b_mag_in  = B[WORD_MID-1] ? ('0 - B) : B;
    b_is_zero = (B == '0);
  end

  // One restoring-division step
  logic [WORD_MID:0] rem_sh;
  logic [WORD_MID:0] rem_sub;
  logic              rem_ge;

  always_comb begin
    rem_sh  = {rem[WORD_MID-1:0], dvd[N-1]};
    rem_ge  = (rem_sh >= {1'b0, b_mag});
    rem_sub = rem_sh - {1'b0, b_mag};
  end

  // Final signed, saturated result
  logic [WORD_MID-1:0] res_c;
  logic                res_ovf;

  always_comb begin
    res_c   = '0;
    res_ovf = 1'b0;
    if (dz) begin
      res_c = a_neg ? SAT_NEG : SAT_POS;
    end else if (!sign && (quo > POS_MAX)) begin
      res_c   = SAT_POS;
      res_ovf = 1'b1;
    end else if (sign && (quo > NEG_MAX)) begin
      res_c   = SAT_NEG;
      res_ovf = 1'b1;
    end else if (sign) begin
      res_c = '0 - quo[WORD_MID-1:0];
    end else begin
      res_c = quo[WORD_MID-1:0];
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = b_is_zero ? FINISH : DIVIDE;
        end
      end
      DIVIDE: begin
        if (cnt == '0) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == DIVIDE) || (state == FINISH);
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      dvd      <= '0;
      quo      <= '0;
      rem      <= '0;
      b_mag    <= '0;
      sign     <= 1'b0;
      a_neg    <= 1'b0;
      dz       <= 1'b0;
      done     <= 1'b0;
      C        <= '0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= A[WORD_MID-1] ^ B[WORD_MID-1];
            a_neg <= A[WORD_MID-1];
            b_mag <= b_mag_in;
            dvd   <= {a_mag_in, {FRAC_BITS{1'b0}}};
            rem   <= '0;
            quo   <= '0;
            dz    <= b_is_zero;
            cnt   <= CW'(N - 1);
          end
        end
        DIVIDE: begin
          dvd <= {dvd[N-2:0], 1'b0};
          if (rem_ge) begin
            rem <= rem_sub;
            quo <= {quo[N-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[N-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
        end
        FINISH: begin
          C        <= res_c;
          overflow <= res_ovf;
          div_zero <= dz;
          done     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_div.sv
module tb_sign_div;

  localparam int LAT = 23;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy;
  logic        done;
  logic [15:0] C;
  logic        overflow;
  logic        div_zero;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  sign_div #(.WORD_MID(16), .FRAC_BITS(6)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .C        (C),
    .overflow (overflow),
    .div_zero (div_zero)
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        ovf;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
    end
  endtask

  // Pulse start for the edge E0; returns at E0 + #1
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done; busy must stay high before it and be low with it
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge CLK);
      #1;
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic no_done(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge CLK);
      #1;
      if (done) seen++;
    end
    chk(nm, seen, 0);
  endtask

  vec_t vecs[12];

  initial begin
    int lat;
    int lat2;
    bit bok;

    vecs[0]  = '{"6/2",        16'h0180, 16'h0080, 16'h00C0, 1'b0, 1'b0, LAT};
    vecs[1]  = '{"1/3",        16'h0040, 16'h00C0, 16'h0015, 1'b0, 1'b0, LAT};
    vecs[2]  = '{"1/-3",       16'h0040, 16'hFF40, 16'hFFEB, 1'b0, 1'b0, LAT};
    vecs[3]  = '{"-6/2",       16'hFE80, 16'h0080, 16'hFF40, 1'b0, 1'b0, LAT};
    vecs[4]  = '{"-6/-2",      16'hFE80, 16'hFF80, 16'h00C0, 1'b0, 1'b0, LAT};
    vecs[5]  = '{"0/-3",       16'h0000, 16'hFF40, 16'h0000, 1'b0, 1'b0, LAT};
    vecs[6]  = '{"posmax/lsb", 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0, LAT};
    vecs[7]  = '{"negmax/1",   16'h8000, 16'h0040, 16'h8000, 1'b0, 1'b0, LAT};
    vecs[8]  = '{"negmax/-1",  16'h8000, 16'hFFC0, 16'h7FFF, 1'b1, 1'b0, LAT};
    vecs[9]  = '{"neg/0",      16'hFE80, 16'h0000, 16'h8000, 1'b0, 1'b1, 1};
    vecs[10] = '{"pos/0",      16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1};
    vecs[11] = '{"1/1",        16'h0040, 16'h0040, 16'h0040, 1'b0, 1'b0, LAT};

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst C", C, 0);
    chk("rst ovf", overflow, 0);
    chk("rst dz", div_zero, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(lat, bok);
      chk({vecs[i].name, " lat"}, lat, vecs[i].lat);
      chk({vecs[i].name, " busy"}, bok, 1);
      chk({vecs[i].name, " C"}, C, vecs[i].c);
      chk({vecs[i].name, " ovf"}, overflow, vecs[i].ovf);
      chk({vecs[i].name, " dz"}, div_zero, vecs[i].dz);
      @(posedge CLK);
      #1;
      chk({vecs[i].name, " done pulse"}, done, 0);
      chk({vecs[i].name, " C hold"}, C, vecs[i].c);
    end

    // start held high with operands changing while busy
    @(negedge CLK);
    A = 16'h0180;
    B = 16'h0080;
    start = 1'b1;
    @(posedge CLK);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge CLK);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      A = 16'($urandom);
      B = 16'($urandom);
    end
    chk("held lat1", lat, LAT);
    chk("held C1", C, 16'h00C0);
    A = 16'h0040;
    B = 16'h0040;
    @(posedge CLK);
    #1;
    start = 1'b0;
    A = 16'hFFFF;
    B = 16'h0000;
    wait_done(lat2, bok);
    // Next sampling edge is the one right after the done edge
    chk("held spacing", lat2 + 1, LAT + 1);
    chk("held C2", C, 16'h0040);

    // start pulsed mid-DIVIDE is ignored
    launch(16'h0180, 16'h0080);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    A = 16'h0040;
    B = 16'h00C0;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_done(lat, bok);
    chk("mid start lat", lat, LAT - 6);
    chk("mid start C", C, 16'h00C0);
    no_done("mid start no extra", 30);

    // Reset during DIVIDE aborts
    launch(16'h0040, 16'hFF40);
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort C", C, 0);
    chk("abort ovf", overflow, 0);
    chk("abort dz", div_zero, 0);
    @(negedge CLK);
    RST = 1'b0;
    no_done("abort no done", 30);
    launch(16'h0180, 16'h0080);
    wait_done(lat, bok);
    chk("after abort lat", lat, LAT);
    chk("after abort C", C, 16'h00C0);
    chk("after abort ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
